// File: rtl/uart_pixel_recv_if.sv
// rtl/uart_pixel_recv_if.sv - pixel output bundle of uart_pixel_recv
// master: the receiver driving pixels; slave: the pixel-processing consumer.
interface uart_pixel_recv_if #(
  parameter int PIX_NUM = 65536
);
  localparam int CNT_W = $clog2(PIX_NUM + 1);

  logic [23:0]      pix_rgb;
  logic             pix_valid;
  logic [CNT_W-1:0] pix_cnt;
  logic             img_done;
  logic             frame_err;

  modport master (
    output pix_rgb,
    output pix_valid,
    output pix_cnt,
    output img_done,
    output frame_err
  );

  modport slave (
    input pix_rgb,
    input pix_valid,
    input pix_cnt,
    input img_done,
    input frame_err
  );
endinterface

// File: rtl/uart_pixel_recv.sv
// rtl/uart_pixel_recv.sv - 8N1 UART receiver assembling R,G,B bytes into 24-bit pixels
// Optional partial-pixel idle timeout is enabled by defining UART_RX_TIMEOUT_EN.
module uart_pixel_recv #(
  parameter int CLK_FREQ     = 50000000,
  parameter int UART_BPS     = 115200,
  parameter int PIX_NUM      = 65536,
  parameter int TIMEOUT_BITS = 30
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              uart_rxd,
  uart_pixel_recv_if.master pix_if
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int BAUD_W  = $clog2(BPS_CNT + 1);
  localparam int CNT_W   = $clog2(PIX_NUM + 1);
  localparam logic [BAUD_W-1:0] HALF_END = BAUD_W'(BPS_CNT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_END = BAUD_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0]  PIX_LAST = CNT_W'(PIX_NUM - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic              rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [BAUD_W-1:0] baud_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        byte_idx_q;
  logic [7:0]        red_q, green_q;
  logic [23:0]       pix_rgb_q;
  logic              pix_valid_q;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              img_done_q;
  logic              frame_err_q;
  logic              fall;
  logic              timeout_hit;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign fall      = rxd_prev_q & ~rxd_sync_q;
  assign shift_d   = {rxd_sync_q, shift_q[7:1]};
  assign pix_cnt_d = pix_cnt_q + 1'b1;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_BITS * BPS_CNT;
  localparam int TO_W   = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] idle_cnt_q;

  // Only meaningful while a pixel is partially assembled and the line is idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt_q <= '0;
    end else if (fall || (byte_idx_q == 2'd0) || (state_q != IDLE) || timeout_hit) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == IDLE) && (byte_idx_q != 2'd0) &&
                       (idle_cnt_q == TO_W'(TO_CYC - 1));
`else
  assign timeout_hit = (TIMEOUT_BITS < 0);
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      red_q       <= '0;
      green_q     <= '0;
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_cnt_q   <= '0;
      img_done_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      pix_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          if (fall) begin
            state_q <= START;
          end else if (timeout_hit) begin
            byte_idx_q <= 2'd0;
          end
        end
        START: begin
          if (baud_cnt_q == HALF_END) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            state_q    <= rxd_sync_q ? IDLE : DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt_q == FULL_END) begin
            baud_cnt_q <= '0;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid stop bit so the next start edge is never missed.
          if (baud_cnt_q == FULL_END) begin
            baud_cnt_q <= '0;
            state_q    <= IDLE;
            if (!rxd_sync_q) begin
              frame_err_q <= 1'b1;
              byte_idx_q  <= 2'd0;
            end else begin
              case (byte_idx_q)
                2'd0: begin
                  red_q      <= shift_q;
                  byte_idx_q <= 2'd1;
                end
                2'd1: begin
                  green_q    <= shift_q;
                  byte_idx_q <= 2'd2;
                end
                default: begin
                  pix_rgb_q   <= {red_q, green_q, shift_q};
                  pix_valid_q <= 1'b1;
                  byte_idx_q  <= 2'd0;
                  if (pix_cnt_q == PIX_LAST) begin
                    pix_cnt_q  <= '0;
                    img_done_q <= 1'b1;
                  end else begin
                    pix_cnt_q <= pix_cnt_d;
                  end
                end
              endcase
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix_if.pix_rgb   = pix_rgb_q;
  assign pix_if.pix_valid = pix_valid_q;
  assign pix_if.pix_cnt   = pix_cnt_q;
  assign pix_if.img_done  = img_done_q;
  assign pix_if.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_pixel_recv.sv
// tb/tb_uart_pixel_recv.sv - directed and randomized bench for uart_pixel_recv
// Reference model works at byte level: accepted bytes queue up, every third forms a pixel.
module tb_uart_pixel_recv;
  localparam int CLK_FREQ     = 50000000;
  localparam int UART_BPS     = 781250;
  localparam int BPS          = CLK_FREQ / UART_BPS;
  localparam int PIX_NUM      = 4;
  localparam int TIMEOUT_BITS = 30;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;

  always #10 clk = ~clk;

  uart_pixel_recv_if #(.PIX_NUM(PIX_NUM)) pif ();

  uart_pixel_recv #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .PIX_NUM(PIX_NUM), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd), .pix_if(pif)
  );

  int   n_cmp = 0, n_fail = 0;
  int   n_valid = 0, n_ferr = 0, n_both = 0;
  logic done_at_valid = 1'b0;

  always @(negedge clk) begin
    if (pif.pix_valid === 1'b1) begin
      n_valid++;
      done_at_valid = pif.img_done;
    end
    if (pif.frame_err === 1'b1) n_ferr++;
    if (pif.pix_valid === 1'b1 && pif.frame_err === 1'b1) n_both++;
  end

  logic [7:0]  mq[$];
  logic [23:0] exp_rgb = '0;
  int          exp_cnt = 0, exp_valid = 0, exp_ferr = 0;
  logic        exp_done = 1'b0;

  task automatic model_byte(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) begin
      exp_ferr++;
      mq.delete();
    end else begin
      mq.push_back(b);
      if (mq.size() == 3) begin
        exp_rgb = {mq[0], mq[1], mq[2]};
        mq.delete();
        exp_valid++;
        exp_cnt++;
        if (exp_cnt == PIX_NUM) begin
          exp_cnt  = 0;
          exp_done = 1'b1;
        end
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_rgb  = '0;
    exp_cnt  = 0;
    exp_done = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rgb"}, 32'(pif.pix_rgb), 32'(exp_rgb));
    chk({tag, ".cnt"}, 32'(pif.pix_cnt), 32'(exp_cnt));
    chk({tag, ".done"}, 32'(pif.img_done), 32'(exp_done));
    chk({tag, ".nvalid"}, 32'(n_valid), 32'(exp_valid));
    chk({tag, ".nferr"}, 32'(n_ferr), 32'(exp_ferr));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".rgb0"}, 32'(pif.pix_rgb), 32'h0);
    chk({tag, ".cnt0"}, 32'(pif.pix_cnt), 32'h0);
    chk({tag, ".done0"}, 32'(pif.img_done), 32'h0);
    chk({tag, ".valid0"}, 32'(pif.pix_valid), 32'h0);
    chk({tag, ".ferr0"}, 32'(pif.frame_err), 32'h0);
  endtask

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (BPS) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_ok);
    rxd = 1'b1;
    model_byte(b, stop_ok);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] p);
    send_byte(p[23:16], 1'b1);
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check_zero(tag);
    model_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  rb;
    logic [7:0]  gb;
    logic        ok;
    logic [23:0] want6;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic pixel
    send_pixel(24'h123456);
    check_outputs("t1");
    chk("t1.rgb_const", 32'(pif.pix_rgb), 32'h123456);

    // Short glitch is rejected
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BPS) @(negedge clk);
    check_outputs("t2");

    // Framing error discards the byte and restarts assembly
    send_byte(8'hAA, 1'b0);
    send_pixel(24'h010203);
    check_outputs("t3");
    chk("t3.rgb_const", 32'(pif.pix_rgb), 32'h010203);

    // Image completion and wrap
    do_reset("t4.rst");
    for (int k = 0; k < PIX_NUM; k++) begin
      send_pixel(24'($urandom));
      check_outputs("t4.pix");
      if (k == PIX_NUM - 2) chk("t4.done_before", 32'(done_at_valid), 32'h0);
    end
    chk("t4.done_with_valid", 32'(done_at_valid), 32'h1);
    chk("t4.cnt_wrap", 32'(pif.pix_cnt), 32'h0);
    send_pixel(24'($urandom));
    check_outputs("t4.fifth");
    chk("t4.cnt_fifth", 32'(pif.pix_cnt), 32'h1);

    // Reset during bit 4 of the G byte
    send_byte(8'($urandom), 1'b1);
    gb = 8'($urandom);
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(gb[i]);
    rxd = gb[4];
    repeat (BPS / 2) @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("t5.rst");
    model_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_pixel(24'hFF0080);
    check_outputs("t5");
    chk("t5.rgb_const", 32'(pif.pix_rgb), 32'hFF0080);

    // Long idle after a partial pixel
    send_byte(8'h11, 1'b1);
    repeat ((TIMEOUT_BITS + 1) * BPS) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
    mq.delete();
    want6 = 24'h223344;
`else
    want6 = 24'h112233;
`endif
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check_outputs("t6");
    chk("t6.rgb_const", 32'(pif.pix_rgb), 32'(want6));

    // Randomized byte stream with occasional framing errors and gaps
    for (int k = 0; k < 24; k++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_byte(rb, ok);
      check_outputs("rand");
      repeat ($urandom_range(0, 3 * BPS)) @(negedge clk);
    end

    chk("no_overlap", 32'(n_both), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
